pusch_symbol_scheduler: RTL
===========================

Name: pusch_symbol_scheduler

Overview:
Slot-level sequencer for the PUSCH back end. For each OFDM symbol in a configured range it starts the resource element mapper into one of two ping-pong banks and starts the IFFT on the other bank. It tracks which banks are free or full, so the mapper never overwrites a bank the IFFT has not consumed. It also marks each symbol as DMRS or data from a symbol mask.

Parameters:
NUM_SYM, 14, OFDM symbols per slot
SYM_W, 4, width of symbol index fields
DMRS_MASK, 14'b00000000000100, bit k=1 means symbol k carries DMRS (default: symbol 2)
TIMEOUT_CYC, 8192, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
slot_start  in  1  one-cycle pulse that begins a slot
sym_start  in  SYM_W  first symbol of the allocation; sampled on slot_start
sym_end  in  SYM_W  last symbol of the allocation (inclusive); sampled on slot_start
rem_done  in  1  pulse: the mapper has finished writing the current symbol
ifft_done  in  1  pulse: the IFFT has finished reading the current bank
rem_start  out  1  pulse: start the mapper on rem_sym_idx / rem_bank
rem_sym_idx  out  SYM_W  symbol index being mapped
rem_is_dmrs  out  1  DMRS_MASK[rem_sym_idx]
rem_bank  out  1  ping-pong bank the mapper writes
ifft_start  out  1  pulse: start the IFFT on ifft_bank
ifft_bank  out  1  bank the IFFT reads
ifft_sym_idx  out  SYM_W  symbol index in ifft_bank
slot_busy  out  1  high from an accepted slot_start until slot_done
slot_done  out  1  pulse after the last symbol's ifft_done
cfg_err  out  1  pulse: slot_start rejected because the configuration is illegal
timeout_err  out  1  watchdog abort pulse (optional feature)

Behaviour:
- Reset: all outputs are 0, both banks are FREE, both FSMs are IDLE.
- Bank state per bank: FREE, FULL or READ.
- Writer FSM: IDLE -> WAIT_BANK -> WRITE -> (next symbol: WAIT_BANK | last symbol: IDLE).
- Reader FSM: IDLE -> WAIT_FULL -> READ -> WAIT_FULL, or IDLE after the last symbol.
- Accepting a slot: slot_start in IDLE with sym_start <= sym_end and sym_end < NUM_SYM.
  - Latches the range and sets slot_busy at T+1.
  - Writer bank pointer and reader bank pointer both reset to 0.
- Rejecting a slot: an illegal range produces a cfg_err pulse at T+1. No other output changes.
- slot_start while slot_busy is ignored and does not raise cfg_err.
- WAIT_BANK: when bank[wptr] is FREE, rem_start pulses for 1 cycle. rem_sym_idx, rem_is_dmrs and rem_bank are registered with it and held stable until the next rem_start.
  - First rem_start occurs at T+1 after the accepting slot_start.
- WRITE: on rem_done, bank[wptr] becomes FULL next cycle, wptr toggles and the symbol index increments.
  - If the symbol was sym_end, the writer returns to IDLE.
- WAIT_FULL: when bank[rptr] is FULL, ifft_start pulses and the bank becomes READ.
  - ifft_sym_idx is the index stored for that bank at write time.
  - Earliest ifft_start is 2 cycles after rem_done.
- READ: on ifft_done, bank[rptr] becomes FREE next cycle and rptr toggles.
- Ordering: the reader always consumes banks in write order. Banks strictly alternate 0,1,0,...
- rem_done and ifft_done in the same cycle are both applied. A bank freed in cycle C may be re-armed by rem_start at C+2 at the earliest.
- rem_done outside WRITE and ifft_done outside READ are ignored.
- Slot end: on the ifft_done of symbol sym_end, slot_done pulses next cycle and slot_busy drops in the same cycle. A new slot may then start.
- Single symbol (sym_start == sym_end): exactly one rem_start and one ifft_start.
- Reset asserted mid-slot: immediate return to the reset state. No slot_done is produced.

Optional Feature:
PUSCH_SCHED_TIMEOUT_EN:
- Defined: a 14-bit counter runs while the writer is in WRITE or the reader is in READ, and clears on each rem_done or ifft_done.
  - Reaching TIMEOUT_CYC pulses timeout_err and aborts the slot: both FSMs go to IDLE, both banks go FREE, slot_busy drops, and slot_done is not pulsed.
- Undefined: no counter exists, timeout_err is tied to 0, and the FSMs wait indefinitely.

Test Plan:
- Range 0..13 with rem_done 5 cycles after each rem_start and ifft_done 20 cycles after each ifft_start -> 14 rem_start, 14 ifft_start, banks alternate 0,1,…; rem_is_dmrs=1 only for symbol 2; exactly one slot_done.
- slow IFFT (ifft_done 100 cycles after start), fast mapper -> third rem_start is withheld until bank 0's ifft_done and occurs exactly 2 cycles after it; no bank is ever written while READ.
- sym_start=5, sym_end=3 -> cfg_err pulse at T+1, slot_busy stays 0, no rem_start; sym_end=14 -> same.
- Range 7..7 -> one rem_start (idx 7, bank 0), one ifft_start (idx 7), then slot_done; a second slot_start while busy is ignored.
- rem_done and ifft_done in the same cycle -> both bank updates are applied; reset asserted at symbol 4 -> all outputs 0 and no slot_done.
- With PUSCH_SCHED_TIMEOUT_EN and TIMEOUT_CYC=64, ifft_done withheld -> timeout_err at cycle 64 of READ, slot_busy drops, and the next slot runs normally.

Source files
------------

// File: rtl/pusch_symbol_scheduler.sv
// PUSCH slot sequencer: runs the RE mapper and the IFFT over two ping-pong banks.
// Optional watchdog abort is compiled in when PUSCH_SCHED_TIMEOUT_EN is defined.
module pusch_symbol_scheduler #(
  parameter int                 NUM_SYM     = 14,
  parameter int                 SYM_W       = 4,
  parameter logic [NUM_SYM-1:0] DMRS_MASK   = 14'b00000000000100,
  parameter int                 TIMEOUT_CYC = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slot_start,
  input  logic [SYM_W-1:0] sym_start,
  input  logic [SYM_W-1:0] sym_end,
  input  logic             rem_done,
  input  logic             ifft_done,
  output logic             rem_start,
  output logic [SYM_W-1:0] rem_sym_idx,
  output logic             rem_is_dmrs,
  output logic             rem_bank,
  output logic             ifft_start,
  output logic             ifft_bank,
  output logic [SYM_W-1:0] ifft_sym_idx,
  output logic             slot_busy,
  output logic             slot_done,
  output logic             cfg_err,
  output logic             timeout_err
);

  typedef enum logic [1:0] {BANK_FREE, BANK_FULL, BANK_READ} bank_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT_BANK, W_WRITE}     wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT_FULL, R_READ}      rd_state_e;

  // The watchdog counter is 14 bits wide, so the limit has to fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 16383) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..16383");
  end

  wr_state_e        wr_state;
  rd_state_e        rd_state;
  bank_state_e      bank_st  [2];
  logic [SYM_W-1:0] bank_sym [2];
  logic             wptr;
  logic             rptr;
  logic [SYM_W-1:0] wr_idx;
  logic [SYM_W-1:0] end_q;
  logic             slot_ok;
  logic             wd_fire;

  assign slot_ok = (sym_start <= sym_end) && (int'(sym_end) < NUM_SYM);

`ifdef PUSCH_SCHED_TIMEOUT_EN
  localparam logic [13:0] WD_LAST = 14'(TIMEOUT_CYC - 1);

  logic [13:0] wd_cnt;
  logic        wd_run;

  // A done pulse restarts the count, so it also wins over a coinciding expiry.
  assign wd_run  = (wr_state == W_WRITE) || (rd_state == R_READ);
  assign wd_fire = wd_run && !rem_done && !ifft_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if (rem_done || ifft_done || wd_fire) begin
        wd_cnt <= '0;
      end else if (wd_run) begin
        wd_cnt <= wd_cnt + 14'd1;
      end
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state     <= W_IDLE;
      rd_state     <= R_IDLE;
      // NOTE: the per-bank arrays are two-entry flop arrays, not RAM, so they are reset like any other register.
      bank_st[0]   <= BANK_FREE;
      bank_st[1]   <= BANK_FREE;
      bank_sym[0]  <= '0;
      bank_sym[1]  <= '0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      wr_idx       <= '0;
      end_q        <= '0;
      rem_start    <= 1'b0;
      rem_sym_idx  <= '0;
      rem_is_dmrs  <= 1'b0;
      rem_bank     <= 1'b0;
      ifft_start   <= 1'b0;
      ifft_bank    <= 1'b0;
      ifft_sym_idx <= '0;
      slot_busy    <= 1'b0;
      slot_done    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      // NOTE: all updates are non-blocking, so both FSMs see the bank states as they stood before this edge.
      rem_start  <= 1'b0;
      ifft_start <= 1'b0;
      slot_done  <= 1'b0;
      cfg_err    <= 1'b0;

      if (wd_fire) begin
        wr_state   <= W_IDLE;
        rd_state   <= R_IDLE;
        bank_st[0] <= BANK_FREE;
        bank_st[1] <= BANK_FREE;
        slot_busy  <= 1'b0;
      end else begin
        // Both FSMs are idle whenever slot_busy is low, so the first symbol can start at once.
        if (slot_start && !slot_busy) begin
          if (slot_ok) begin
            end_q       <= sym_end;
            slot_busy   <= 1'b1;
            wptr        <= 1'b1;
            rptr        <= 1'b0;
            rem_start   <= 1'b1;
            rem_sym_idx <= sym_start;
            rem_is_dmrs <= DMRS_MASK[sym_start];
            rem_bank    <= 1'b0;
            wr_state    <= W_WRITE;
            rd_state    <= R_WAIT_FULL;
          end else begin
            cfg_err <= 1'b1;
          end
        end

        case (wr_state)
          W_WAIT_BANK: begin
            if (bank_st[wptr] == BANK_FREE) begin
              rem_start   <= 1'b1;
              rem_sym_idx <= wr_idx;
              rem_is_dmrs <= DMRS_MASK[wr_idx];
              rem_bank    <= wptr;
              wptr        <= ~wptr;
              wr_state    <= W_WRITE;
            end
          end
          W_WRITE: begin
            if (rem_done) begin
              bank_st[rem_bank]  <= BANK_FULL;
              bank_sym[rem_bank] <= rem_sym_idx;
              if (rem_sym_idx == end_q) begin
                wr_state <= W_IDLE;
              end else begin
                wr_idx   <= rem_sym_idx + SYM_W'(1);
                wr_state <= W_WAIT_BANK;
              end
            end
          end
          default: ;
        endcase

        case (rd_state)
          R_WAIT_FULL: begin
            if (bank_st[rptr] == BANK_FULL) begin
              bank_st[rptr] <= BANK_READ;
              ifft_start    <= 1'b1;
              ifft_bank     <= rptr;
              ifft_sym_idx  <= bank_sym[rptr];
              rd_state      <= R_READ;
            end
          end
          R_READ: begin
            if (ifft_done) begin
              bank_st[rptr] <= BANK_FREE;
              rptr          <= ~rptr;
              if (ifft_sym_idx == end_q) begin
                rd_state  <= R_IDLE;
                slot_done <= 1'b1;
                slot_busy <= 1'b0;
              end else begin
                rd_state <= R_WAIT_FULL;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
